// File: rtl/vx_fetch_sched.sv
// Warp fetch scheduler: keeps per-warp PC, thread mask and stall state, and issues
// one round-robin fetch request at a time through a single held output register.
module vx_fetch_sched #(
    parameter int          NUM_WARPS    = 4,
    parameter int          NUM_THREADS  = 4,
    parameter int          UUID_BITS    = 16,
    parameter logic [31:0] STARTUP_ADDR = 32'h80000000,
    localparam int         NW_BITS      = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spawn_valid,
    input  logic [NW_BITS-1:0]     spawn_wid,
    input  logic [31:0]            spawn_pc,
    input  logic [NUM_THREADS-1:0] spawn_tmask,
    input  logic                   unlock_valid,
    input  logic [NW_BITS-1:0]     unlock_wid,
    input  logic                   branch_valid,
    input  logic [NW_BITS-1:0]     branch_wid,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_dest,
    input  logic                   tmc_valid,
    input  logic [NW_BITS-1:0]     tmc_wid,
    input  logic [NUM_THREADS-1:0] tmc_tmask,
    output logic                   ifetch_req_valid,
    output logic [UUID_BITS-1:0]   ifetch_req_uuid,
    output logic [NUM_THREADS-1:0] ifetch_req_tmask,
    output logic [NW_BITS-1:0]     ifetch_req_wid,
    output logic [31:0]            ifetch_req_PC,
    input  logic                   ifetch_req_ready,
    output logic                   busy
);

    logic [NUM_WARPS-1:0]   active_q, active_d;
    logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
    logic [31:0]            pc_q [NUM_WARPS];
    logic [31:0]            pc_d [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
    logic [NW_BITS-1:0]     last_wid_q, last_wid_d;
    logic [UUID_BITS-1:0]   uuid_q, uuid_d;

    logic                   req_valid_q, req_valid_d;
    logic [UUID_BITS-1:0]   req_uuid_q, req_uuid_d;
    logic [NUM_THREADS-1:0] req_tmask_q, req_tmask_d;
    logic [NW_BITS-1:0]     req_wid_q, req_wid_d;
    logic [31:0]            req_pc_q, req_pc_d;

    logic [NUM_WARPS-1:0]   spawn_hit, unlock_hit, branch_hit, tmc_hit, eligible;
    logic                   slot_free, found;
    logic [NW_BITS-1:0]     sel_wid, cand;

    // A warp touched by any control event this cycle sits out arbitration.
    always_comb begin : decode
        for (int w = 0; w < NUM_WARPS; w++) begin
            spawn_hit[w]  = spawn_valid  && (spawn_wid  == NW_BITS'(w));
            unlock_hit[w] = unlock_valid && (unlock_wid == NW_BITS'(w));
            branch_hit[w] = branch_valid && (branch_wid == NW_BITS'(w));
            tmc_hit[w]    = tmc_valid    && (tmc_wid    == NW_BITS'(w));
        end
        eligible = active_q & ~stalled_q & ~(spawn_hit | unlock_hit | branch_hit | tmc_hit);
    end

    // NOTE: combinational logic uses blocking '=' so each loop step sees the previous one.
    always_comb begin : rr_select
        found   = 1'b0;
        sel_wid = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = last_wid_q + NW_BITS'(i);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                sel_wid = cand;
            end
        end
    end

    assign slot_free = !req_valid_q || ifetch_req_ready;

    // NOTE: every target gets a hold value first, so no path can infer a latch.
    always_comb begin : next_state
        active_d    = active_q;
        stalled_d   = stalled_q;
        pc_d        = pc_q;
        tmask_d     = tmask_q;
        last_wid_d  = last_wid_q;
        uuid_d      = uuid_q;
        req_valid_d = req_valid_q;
        req_uuid_d  = req_uuid_q;
        req_tmask_d = req_tmask_q;
        req_wid_d   = req_wid_q;
        req_pc_d    = req_pc_q;

        if (slot_free && found) begin
            req_valid_d        = 1'b1;
            req_wid_d          = sel_wid;
            req_pc_d           = pc_q[sel_wid];
            req_tmask_d        = tmask_q[sel_wid];
            req_uuid_d         = uuid_q;
            stalled_d[sel_wid] = 1'b1;
            pc_d[sel_wid]      = pc_q[sel_wid] + 32'd4;
            uuid_d             = uuid_q + 1'b1;
            last_wid_d         = sel_wid;
        end else if (slot_free) begin
            req_valid_d = 1'b0;
        end

        // The issued warp is never an event target, so these cannot collide with issue.
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (spawn_hit[w]) begin
                active_d[w]  = 1'b1;
                stalled_d[w] = 1'b0;
                pc_d[w]      = spawn_pc;
                tmask_d[w]   = spawn_tmask;
            end else if (active_q[w]) begin
                if (tmc_hit[w] && (tmc_tmask == '0)) begin
                    active_d[w]  = 1'b0;
                    stalled_d[w] = 1'b0;
                    tmask_d[w]   = '0;
                end else begin
                    if (tmc_hit[w]) tmask_d[w] = tmc_tmask;
                    if (branch_hit[w]) begin
                        stalled_d[w] = 1'b0;
                        if (branch_taken) pc_d[w] = branch_dest;
                    end else if (unlock_hit[w]) begin
                        stalled_d[w] = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: the per-warp PC/mask arrays are reset because warp 0 must boot from them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= (w == 0) ? STARTUP_ADDR : 32'd0;
                tmask_q[w] <= (w == 0) ? NUM_THREADS'(1) : NUM_THREADS'(0);
            end
            active_q    <= NUM_WARPS'(1);
            stalled_q   <= '0;
            last_wid_q  <= NW_BITS'(NUM_WARPS - 1);
            uuid_q      <= '0;
            req_valid_q <= 1'b0;
            req_uuid_q  <= '0;
            req_tmask_q <= '0;
            req_wid_q   <= '0;
            req_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            tmask_q     <= tmask_d;
            active_q    <= active_d;
            stalled_q   <= stalled_d;
            last_wid_q  <= last_wid_d;
            uuid_q      <= uuid_d;
            req_valid_q <= req_valid_d;
            req_uuid_q  <= req_uuid_d;
            req_tmask_q <= req_tmask_d;
            req_wid_q   <= req_wid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    assign ifetch_req_valid = req_valid_q;
    assign ifetch_req_uuid  = req_uuid_q;
    assign ifetch_req_tmask = req_tmask_q;
    assign ifetch_req_wid   = req_wid_q;
    assign ifetch_req_PC    = req_pc_q;
    assign busy             = (|active_q) || req_valid_q;

endmodule

// File: tb/tb_vx_fetch_sched.sv
// Self-checking bench for vx_fetch_sched: directed vector table, hand-written
// corner sequences, then random traffic checked against a behavioural model.
module tb_vx_fetch_sched;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int UB  = 4;
    localparam int NWB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           spawn_valid, unlock_valid, branch_valid, branch_taken, tmc_valid;
    logic [NWB-1:0] spawn_wid, unlock_wid, branch_wid, tmc_wid;
    logic [31:0]    spawn_pc, branch_dest;
    logic [NT-1:0]  spawn_tmask, tmc_tmask;
    logic           ifetch_req_ready;
    logic           ifetch_req_valid;
    logic [UB-1:0]  ifetch_req_uuid;
    logic [NT-1:0]  ifetch_req_tmask;
    logic [NWB-1:0] ifetch_req_wid;
    logic [31:0]    ifetch_req_PC;
    logic           busy;

    vx_fetch_sched #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .UUID_BITS(UB), .STARTUP_ADDR(32'h80000000)
    ) dut (
        .clk(clk), .reset(reset),
        .spawn_valid(spawn_valid), .spawn_wid(spawn_wid), .spawn_pc(spawn_pc), .spawn_tmask(spawn_tmask),
        .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
        .branch_valid(branch_valid), .branch_wid(branch_wid), .branch_taken(branch_taken),
        .branch_dest(branch_dest),
        .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
        .ifetch_req_valid(ifetch_req_valid), .ifetch_req_uuid(ifetch_req_uuid),
        .ifetch_req_tmask(ifetch_req_tmask), .ifetch_req_wid(ifetch_req_wid),
        .ifetch_req_PC(ifetch_req_PC), .ifetch_req_ready(ifetch_req_ready), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: warp table plus one pending-request slot.
    bit            m_active  [NW];
    bit            m_stalled [NW];
    logic [31:0]   m_pc      [NW];
    logic [NT-1:0] m_tmask   [NW];
    int            m_last, m_uuid;
    bit            m_valid;
    int            m_wid, m_ruuid;
    logic [31:0]   m_rpc;
    logic [NT-1:0] m_rtmask;

    function automatic bit touched(input int w);
        return (spawn_valid  && int'(spawn_wid)  == w) || (unlock_valid && int'(unlock_wid) == w) ||
               (branch_valid && int'(branch_wid) == w) || (tmc_valid    && int'(tmc_wid)    == w);
    endfunction

    task automatic model_step();
        bit was_active [NW];
        bit slot;
        int pick;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                m_active[w]  = (w == 0);
                m_stalled[w] = 1'b0;
                m_pc[w]      = (w == 0) ? 32'h80000000 : 32'h0;
                m_tmask[w]   = (w == 0) ? NT'(1) : NT'(0);
            end
            m_last  = NW - 1;
            m_uuid  = 0;
            m_valid = 1'b0;
            return;
        end
        was_active = m_active;
        slot = !m_valid || ifetch_req_ready;
        pick = -1;
        if (slot) begin
            for (int i = 1; i <= NW; i++) begin
                int w;
                w = (m_last + i) % NW;
                if (pick < 0 && m_active[w] && !m_stalled[w] && !touched(w)) pick = w;
            end
        end
        if (pick >= 0) begin
            m_valid         = 1'b1;
            m_wid           = pick;
            m_rpc           = m_pc[pick];
            m_rtmask        = m_tmask[pick];
            m_ruuid         = m_uuid;
            m_stalled[pick] = 1'b1;
            m_pc[pick]      = m_pc[pick] + 32'd4;
            m_uuid          = (m_uuid + 1) % (1 << UB);
            m_last          = pick;
        end else if (slot) begin
            m_valid = 1'b0;
        end
        // Events in rising priority: later ones overwrite earlier ones.
        if (unlock_valid && was_active[unlock_wid]) m_stalled[unlock_wid] = 1'b0;
        if (branch_valid && was_active[branch_wid]) begin
            m_stalled[branch_wid] = 1'b0;
            if (branch_taken) m_pc[branch_wid] = branch_dest;
        end
        if (tmc_valid && was_active[tmc_wid]) begin
            m_tmask[tmc_wid] = tmc_tmask;
            if (tmc_tmask == '0) begin
                m_active[tmc_wid]  = 1'b0;
                m_stalled[tmc_wid] = 1'b0;
            end
        end
        if (spawn_valid) begin
            m_active[spawn_wid]  = 1'b1;
            m_stalled[spawn_wid] = 1'b0;
            m_pc[spawn_wid]      = spawn_pc;
            m_tmask[spawn_wid]   = spawn_tmask;
        end
    endtask

    task automatic cmp_model();
        bit m_busy;
        m_busy = m_valid;
        for (int w = 0; w < NW; w++) m_busy = m_busy || m_active[w];
        if (m_valid)
            check("model_cycle",
                  {busy, ifetch_req_valid, ifetch_req_wid, ifetch_req_tmask, ifetch_req_uuid, ifetch_req_PC},
                  {m_busy, 1'b1, NWB'(m_wid), m_rtmask, UB'(m_ruuid), m_rpc});
        else
            check("model_cycle", {busy, ifetch_req_valid}, {m_busy, 1'b0});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic idle();
        spawn_valid  = 1'b0;
        unlock_valid = 1'b0;
        branch_valid = 1'b0;
        tmc_valid    = 1'b0;
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (ifetch_req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_req_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          unl;
        bit          e_valid;
        bit          e_busy;
        logic [31:0] e_pc;
        int          e_uuid;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Boot, 5-cycle backpressure, stall release latency.
        vecs[0]  = '{1, 1, 0, 0, 1, 32'h0,        0};
        vecs[1]  = '{0, 1, 0, 1, 1, 32'h80000000, 0};
        vecs[2]  = '{0, 0, 0, 1, 1, 32'h80000000, 0};
        vecs[3]  = '{0, 0, 0, 1, 1, 32'h80000000, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 32'h80000000, 0};
        vecs[5]  = '{0, 0, 0, 1, 1, 32'h80000000, 0};
        vecs[6]  = '{0, 0, 0, 1, 1, 32'h80000000, 0};
        vecs[7]  = '{0, 1, 0, 0, 1, 32'h0,        0};
        vecs[8]  = '{0, 1, 0, 0, 1, 32'h0,        0};
        vecs[9]  = '{0, 1, 1, 0, 1, 32'h0,        0};
        vecs[10] = '{0, 1, 0, 1, 1, 32'h80000004, 1};
        vecs[11] = '{0, 0, 0, 1, 1, 32'h80000004, 1};
        vecs[12] = '{0, 1, 0, 0, 1, 32'h0,        0};

        idle();
        reset = 1'b1;
        ifetch_req_ready = 1'b1;
        spawn_wid = '0; spawn_pc = '0; spawn_tmask = '0;
        unlock_wid = '0; branch_wid = '0; branch_taken = 1'b0; branch_dest = '0;
        tmc_wid = '0; tmc_tmask = '0;

        for (int i = 0; i < 13; i++) begin
            reset            = vecs[i].rst;
            ifetch_req_ready = vecs[i].rdy;
            unlock_valid     = vecs[i].unl;
            unlock_wid       = '0;
            tick();
            check($sformatf("vec%0d_valid", i), {63'd0, ifetch_req_valid}, {63'd0, vecs[i].e_valid});
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_pc", i), {32'd0, ifetch_req_PC}, {32'd0, vecs[i].e_pc});
                check($sformatf("vec%0d_uuid", i), {60'd0, ifetch_req_uuid}, 64'(vecs[i].e_uuid));
                check($sformatf("vec%0d_wid_tmask", i), {58'd0, ifetch_req_wid, ifetch_req_tmask},
                      {58'd0, 2'd0, 4'b0001});
            end
        end
        idle();

        // Reset while a request is held discards it regardless of ready.
        unlock_valid = 1'b1; unlock_wid = 2'd0; ifetch_req_ready = 1'b0;
        tick();
        idle();
        tick();
        check("held_before_reset", {63'd0, ifetch_req_valid}, 64'd1);
        do_reset();
        check("reset_discards_valid", {63'd0, ifetch_req_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd1);

        // Round-robin across four warps.
        begin
            int          exp_w  [6];
            logic [31:0] exp_pc [6];
            exp_w  = '{0, 1, 2, 3, 0, 1};
            exp_pc = '{32'h80000000, 32'h100, 32'h200, 32'h300, 32'h80000004, 32'h104};
            spawn_valid = 1'b1; spawn_tmask = 4'hF;
            for (int w = 1; w < 4; w++) begin
                spawn_wid = NWB'(w);
                spawn_pc  = 32'(w * 256);
                tick();
            end
            idle();
            ifetch_req_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                wait_req();
                check($sformatf("rr%0d_wid", k), {62'd0, ifetch_req_wid}, 64'(exp_w[k]));
                check($sformatf("rr%0d_pc", k), {32'd0, ifetch_req_PC}, {32'd0, exp_pc[k]});
                check($sformatf("rr%0d_uuid", k), {60'd0, ifetch_req_uuid}, 64'(k));
                unlock_valid = 1'b1;
                unlock_wid   = NWB'(exp_w[k]);
                tick();
                idle();
            end
        end

        // Branch taken / not taken on warp 2.
        do_reset();
        spawn_valid = 1'b1; spawn_wid = 2'd2; spawn_pc = 32'h200; spawn_tmask = 4'h3;
        tick();
        idle();
        wait_req();
        check("br_first_wid", {62'd0, ifetch_req_wid}, 64'd0);
        tick();
        wait_req();
        check("br_w2_pc", {32'd0, ifetch_req_PC}, 64'h200);
        check("br_w2_tmask", {60'd0, ifetch_req_tmask}, 64'h3);
        tick();
        branch_valid = 1'b1; branch_wid = 2'd2; branch_taken = 1'b1; branch_dest = 32'h40;
        tick();
        idle();
        wait_req();
        check("br_taken_wid", {62'd0, ifetch_req_wid}, 64'd2);
        check("br_taken_pc", {32'd0, ifetch_req_PC}, 64'h40);
        tick();
        branch_valid = 1'b1; branch_wid = 2'd2; branch_taken = 1'b0; branch_dest = 32'h999;
        tick();
        idle();
        wait_req();
        check("br_not_taken_pc", {32'd0, ifetch_req_PC}, 64'h44);

        // Deactivation of the only warp while its request is held.
        do_reset();
        ifetch_req_ready = 1'b0;
        tick();
        tmc_valid = 1'b1; tmc_wid = 2'd0; tmc_tmask = 4'h0;
        tick();
        idle();
        check("tmc_held_valid", {63'd0, ifetch_req_valid}, 64'd1);
        check("tmc_held_pc", {32'd0, ifetch_req_PC}, 64'h80000000);
        check("tmc_held_busy", {63'd0, busy}, 64'd1);
        ifetch_req_ready = 1'b1;
        tick();
        check("tmc_fired_valid", {63'd0, ifetch_req_valid}, 64'd0);
        check("tmc_fired_busy", {63'd0, busy}, 64'd0);
        unlock_valid = 1'b1; unlock_wid = 2'd0;
        tick();
        idle();
        tick();
        tick();
        check("tmc_no_more_req", {62'd0, busy, ifetch_req_valid}, 64'd0);

        // UUID wrap with a 4-bit counter.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            wait_req();
            check($sformatf("uuid_wrap%0d", k), {60'd0, ifetch_req_uuid}, 64'(k % 16));
            unlock_valid = 1'b1; unlock_wid = 2'd0;
            tick();
            idle();
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset            = ($urandom_range(0, 255) == 0);
            ifetch_req_ready = ($urandom_range(0, 3) != 0);
            spawn_valid      = ($urandom_range(0, 7) == 0);
            spawn_wid        = NWB'($urandom);
            spawn_pc         = $urandom;
            spawn_tmask      = NT'($urandom);
            unlock_valid     = ($urandom_range(0, 2) == 0);
            unlock_wid       = NWB'($urandom);
            branch_valid     = ($urandom_range(0, 3) == 0);
            branch_wid       = NWB'($urandom);
            branch_taken     = $urandom_range(0, 1) == 1;
            branch_dest      = $urandom;
            tmc_valid        = ($urandom_range(0, 9) == 0);
            tmc_wid          = NWB'($urandom);
            tmc_tmask        = ($urandom_range(0, 2) == 0) ? NT'(0) : NT'($urandom);
            tick();
        end
        idle();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/vx_fetch_sched.md
VX_FETCH_SCHED -- requirements
Module: VX_fetch_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of hardware warps (power of 2, >=2).
REQ-002 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-003 SHALL have parameter UUID_BITS, default 16, fetch-request tag width.
REQ-004 SHALL have parameter STARTUP_ADDR, default 32'h80000000, warp-0 boot PC; NW_BITS = clog2(NUM_WARPS).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports spawn_valid/spawn_wid/spawn_pc/spawn_tmask  in  1/NW_BITS/32/NUM_THREADS  activate warp at PC with mask.
REQ-008 SHALL have ports unlock_valid/unlock_wid  in  1/NW_BITS  decode releases the fetch stall of a warp.
REQ-009 SHALL have ports branch_valid/branch_wid/branch_taken/branch_dest  in  1/NW_BITS/1/32  branch resolution; also releases the stall.
REQ-010 SHALL have ports tmc_valid/tmc_wid/tmc_tmask  in  1/NW_BITS/NUM_THREADS  thread-mask update.
REQ-011 SHALL have ports ifetch_req_valid/uuid/tmask/wid/PC  out  1/UUID_BITS/NUM_THREADS/NW_BITS/32  fetch request to icache stage.
REQ-012 SHALL have port ifetch_req_ready  in  1  downstream accept.
REQ-013 SHALL have port busy  out  1  high while any warp is active.

Function
REQ-014 SHALL hold per warp: active, stalled, PC[31:0], tmask; plus an RR pointer, a UUID counter, and one output register.
REQ-015 SHALL deem warp w eligible iff active[w] & ~stalled[w] & no spawn/unlock/branch/tmc targets w this cycle (registered state only).
REQ-016 SHALL select eligible warp round-robin, searching from (last issued wid + 1) mod NUM_WARPS.
REQ-017 SHALL load output register when (!ifetch_req_valid || ifetch_req_ready) and an eligible warp exists; valid=1, wid, PC[w], tmask[w], uuid=counter.
REQ-018 SHALL, on load, set stalled[w]=1, PC[w]+=4 (mod 2^32), counter+=1 (wraps to 0 at 2^UUID_BITS).
REQ-019 SHALL clear ifetch_req_valid when the request fires and no eligible warp exists.
REQ-020 SHALL keep all ifetch_req_* outputs stable while valid & !ready.
REQ-021 SHALL give one-cycle latency: eligible at cycle t -> valid at t+1; unlock at t -> earliest request at t+2.
REQ-022 SHALL on spawn: active=1, stalled=0, PC=spawn_pc, tmask=spawn_tmask; overwrites an already-active warp.
REQ-023 SHALL on unlock: stalled=0; PC unchanged.
REQ-024 SHALL on branch: stalled=0; if taken PC=branch_dest.
REQ-025 SHALL on tmc: tmask=tmc_tmask; if zero, active=0 and stalled=0.
REQ-026 SHALL resolve same-warp, same-cycle priority: spawn > tmc-zero > branch > unlock; tmc nonzero mask combines with branch/unlock.
REQ-027 SHALL apply events to different warps in the same cycle independently.
REQ-028 SHALL ignore unlock/branch/tmc to an inactive warp, except spawn.
REQ-029 SHALL drive busy = OR of active bits OR ifetch_req_valid.
REQ-030 SHALL not retract or alter a held request due to control events (already-issued fetch completes).

Reset
REQ-031 SHALL on reset: warp 0 active, PC=STARTUP_ADDR, tmask=1 (thread 0 only), stalled=0; other warps inactive, tmask=0, PC=0.
REQ-032 SHALL on reset: ifetch_req_valid=0, uuid counter=0, RR pointer so warp 0 is searched first, busy=1 from first post-reset cycle.
REQ-033 SHALL let reset mid-operation discard any held request at the next edge without waiting for ready.

Verification
REQ-034 SHALL test boot: release reset, ready=1 -> one cycle later valid=1, wid=0, PC=80000000, tmask=0001, uuid=0; no second request until unlock.
REQ-035 SHALL test backpressure: ready=0 for 5 cycles -> outputs unchanged throughout; ready=1 -> fires once, uuid next=1.
REQ-036 SHALL test round-robin: spawn warps 1..3 at PC 100/200/300, unlock each after issue -> wid order 0,1,2,3,0; PCs advance by 4.
REQ-037 SHALL test branch: warp 2 stalled, branch taken dest=40 -> next warp-2 request PC=40; not-taken -> PC=prior+4.
REQ-038 SHALL test deactivation: tmc warp 0 mask 0 with only warp 0 active -> no further requests, busy=0 after pending request fires.
REQ-039 SHALL test UUID wrap: UUID_BITS=4, 17 issues -> uuids 0..15 then 0.
